// File: rtl/mul_seq.sv
// mul_seq: sequential unsigned multiplier that retires two multiplier bits per clock.
// Y holds the low LEN bits of A*B once DONE is high.
module mul_seq #(
  parameter int LEN = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [LEN-1:0] i_a,
  input  logic [LEN-1:0] i_b,
  output logic           o_done,
  output logic [LEN-1:0] o_y
);
  localparam int CW = $clog2(LEN / 2 + 1);
  localparam logic [CW-1:0] ITERS = CW'(LEN / 2);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t         r_state, w_next;
  logic [LEN-1:0] r_acc, r_mcand, r_mplr, w_pp;
  logic [CW-1:0]  r_cnt;
  // Radix-4 partial product: the multiplicand and its double, gated by the two low multiplier bits.
  assign w_pp = (r_mplr[0] ? r_mcand : '0) + (r_mplr[1] ? {r_mcand[LEN-2:0], 1'b0} : '0);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (i_start) begin
        r_acc   <= '0;
        r_mcand <= i_a;
        r_mplr  <= i_b;
        r_cnt   <= ITERS;
      end else if (r_state == S_BUSY) begin
        r_acc   <= r_acc + w_pp;
        r_mcand <= r_mcand << 2;
        r_mplr  <= r_mplr >> 2;
        r_cnt   <= r_cnt - CW'(1);
      end
    end
  end
  always_comb
    w_next = i_start ? S_BUSY
           : (r_state == S_BUSY && r_cnt == CW'(1)) ? S_DONE
           : r_state;
  always_comb begin
    o_done = r_state == S_DONE;
    o_y    = r_acc;
  end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed self-checking bench for mul_seq (LEN=16).
module tb_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        done;
  logic [15:0] y;
  int checks = 0, errors = 0;

  mul_seq #(.LEN(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_a(a), .i_b(b), .o_done(done), .o_y(y)
  );

  always #5 clk = ~clk;

  // Start an operation on the next edge, then count edges until DONE (99 if it never comes).
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, output int lat, output logic [15:0] ty);
    start = 1'b1; a = ta; b = tb;
    @(posedge clk); #1;
    start = 1'b0; a = 'x; b = 'x;
    lat = 99;
    ty = 'x;
    if (done) lat = 0;
    for (int e = 1; e < 16 && lat == 99; e++) begin
      @(posedge clk); #1;
      if (done) begin lat = e; ty = y; end
    end
  endtask

  task automatic test_reset;
    int lat;
    logic [15:0] ty;
    #1;
    checks++;
    if (done !== 1'b0 || y !== 16'h0) begin errors++; $display("FAIL reset_init done=%b y=%h want 0/0000", done, y); end
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b0; a = 'x; b = 'x;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || y !== 16'h0) begin errors++; $display("FAIL reset_midop done=%b y=%h want 0/0000", done, y); end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_idle cycle %0d done=%b want 0", c, done); end
    end
    @(negedge clk);
    run_op(16'h0003, 16'h0005, lat, ty);
  endtask

  task automatic test_basic;
    int lat;
    logic [15:0] ty;
    @(negedge clk);
    run_op(16'h0003, 16'h0005, lat, ty);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
    checks++;
    if (ty !== 16'h000F) begin errors++; $display("FAIL basic_y got %h want 000f", ty); end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || y !== 16'h000F) begin errors++; $display("FAIL basic_hold cycle %0d done=%b y=%h want 1/000f", c, done, y); end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [15:0] ty, ta, tb, exp;
    logic [31:0] full;
    for (int i = 0; i < 100; i++) begin
      ta = 16'(i * 193);
      tb = 16'(i * 1543);
      full = 32'(ta) * 32'(tb);
      exp = full[15:0];
      run_op(ta, tb, lat, ty);
      checks++;
      if (lat !== 8 || ty !== exp) begin errors++; $display("FAIL sweep i=%0d lat=%0d y=%h want 8/%h", i, lat, ty, exp); end
      if (i == 0) begin
        checks++;
        if (ty !== 16'h0000) begin errors++; $display("FAIL sweep_spot0 got %h want 0000", ty); end
      end
      if (i == 1) begin
        checks++;
        if (ty !== 16'h8B47) begin errors++; $display("FAIL sweep_spot1 got %h want 8b47", ty); end
      end
    end
  endtask

  task automatic test_wrap;
    int lat;
    logic [15:0] ty;
    @(negedge clk);
    run_op(16'hFFFF, 16'hFFFF, lat, ty);
    checks++;
    if (lat !== 8 || ty !== 16'h0001) begin errors++; $display("FAIL wrap_ffff lat=%0d y=%h want 8/0001", lat, ty); end
    run_op(16'h8000, 16'h0002, lat, ty);
    checks++;
    if (lat !== 8 || ty !== 16'h0000) begin errors++; $display("FAIL wrap_8000 lat=%0d y=%h want 8/0000", lat, ty); end
  endtask

  task automatic test_restart;
    int lat;
    logic [15:0] ty;
    logic seen = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'd7; b = 16'd9;
    @(posedge clk); #1;
    start = 1'b0; a = 'x; b = 'x;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL restart_clear done=%b want 0", done); end
    repeat (2) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    run_op(16'h0100, 16'h0100, lat, ty);
    checks++;
    if (seen) begin errors++; $display("FAIL restart_first_done saw DONE=1 want 0"); end
    checks++;
    if (lat !== 8 || ty !== 16'h0000) begin errors++; $display("FAIL restart lat=%0d y=%h want 8/0000", lat, ty); end
  endtask

  task automatic test_done_clear;
    int lat;
    logic [15:0] ty;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL clear_pre done=%b want 1", done); end
    start = 1'b1; a = 16'h0003; b = 16'h0005;
    @(posedge clk); #1;
    start = 1'b0; a = 'x; b = 'x;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL clear_post done=%b want 0", done); end
    lat = 99;
    for (int e = 1; e < 16 && lat == 99; e++) begin
      @(posedge clk); #1;
      if (done) lat = e;
    end
    checks++;
    if (lat !== 8 || y !== 16'h000F) begin errors++; $display("FAIL clear_result lat=%0d y=%h want 8/000f", lat, y); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_wrap;
    test_restart;
    test_done_clear;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
